// File: rtl/palette_colour_out_if.sv
// Pixel, palette-write and colour-output signal bundle for palette_colour_out.
// The master drives pixels and palette writes, and the slave returns the colour outputs.
interface palette_colour_out_if #(
    parameter int PEN_W = 4,
    parameter int DAC_W = 4
);
    logic             CE;
    logic [PEN_W-1:0] PEN;
    logic             BORDER;
    logic             BLANK;
    logic             PAL_WR;
    logic             PAL_BORDER;
    logic [PEN_W-1:0] PAL_ADDR;
    logic [4:0]       PAL_DATA;
    logic             RED;
    logic             GREEN;
    logic             BLUE;
    logic             RED_OEn;
    logic             GREEN_OEn;
    logic             BLUE_OEn;
    logic [DAC_W-1:0] DAC_R;
    logic [DAC_W-1:0] DAC_G;
    logic [DAC_W-1:0] DAC_B;
    logic             BLANK_OUT;

    modport master (
        output CE, PEN, BORDER, BLANK, PAL_WR, PAL_BORDER, PAL_ADDR, PAL_DATA,
        input  RED, GREEN, BLUE, RED_OEn, GREEN_OEn, BLUE_OEn,
        input  DAC_R, DAC_G, DAC_B, BLANK_OUT
    );

    modport slave (
        input  CE, PEN, BORDER, BLANK, PAL_WR, PAL_BORDER, PAL_ADDR, PAL_DATA,
        output RED, GREEN, BLUE, RED_OEn, GREEN_OEn, BLUE_OEn,
        output DAC_R, DAC_G, DAC_B, BLANK_OUT
    );
endinterface

// File: rtl/palette_colour_out.sv
// Pen palette with border entry, hardware-colour decode to tri-level RGB,
// and registered pin/DAC outputs behind a two-stage CE-gated pipeline.
module palette_colour_out #(
    parameter int NUM_PENS = 16,
    parameter int PEN_W    = $clog2(NUM_PENS),
    parameter int DAC_W    = 4
) (
    input logic                 CLK_n,
    input logic                 RESET,
    palette_colour_out_if.slave bus
);
    localparam logic [4:0]       BLACK    = 5'h14;
    localparam logic [DAC_W-1:0] DAC_MID  = {1'b1, {(DAC_W-1){1'b0}}};
    localparam logic [DAC_W-1:0] DAC_FULL = {DAC_W{1'b1}};

    // Levels packed as {R,G,B}, two bits each: 0=off, 1=mid, 2=full.
    function automatic logic [5:0] decode_levels(input logic [4:0] colour);
        case (colour)
            5'h00: decode_levels = 6'b01_01_01;
            5'h01: decode_levels = 6'b01_01_01;
            5'h02: decode_levels = 6'b00_10_01;
            5'h03: decode_levels = 6'b10_10_01;
            5'h04: decode_levels = 6'b00_00_01;
            5'h05: decode_levels = 6'b10_00_01;
            5'h06: decode_levels = 6'b00_01_01;
            5'h07: decode_levels = 6'b10_01_01;
            5'h08: decode_levels = 6'b10_00_01;
            5'h09: decode_levels = 6'b10_10_01;
            5'h0A: decode_levels = 6'b10_10_00;
            5'h0B: decode_levels = 6'b10_10_10;
            5'h0C: decode_levels = 6'b10_00_00;
            5'h0D: decode_levels = 6'b10_00_10;
            5'h0E: decode_levels = 6'b10_01_00;
            5'h0F: decode_levels = 6'b10_01_10;
            5'h10: decode_levels = 6'b00_00_01;
            5'h11: decode_levels = 6'b00_10_01;
            5'h12: decode_levels = 6'b00_10_00;
            5'h13: decode_levels = 6'b00_10_10;
            5'h14: decode_levels = 6'b00_00_00;
            5'h15: decode_levels = 6'b00_00_10;
            5'h16: decode_levels = 6'b00_01_00;
            5'h17: decode_levels = 6'b00_01_10;
            5'h18: decode_levels = 6'b01_00_01;
            5'h19: decode_levels = 6'b01_10_01;
            5'h1A: decode_levels = 6'b01_10_00;
            5'h1B: decode_levels = 6'b01_10_10;
            5'h1C: decode_levels = 6'b01_00_00;
            5'h1D: decode_levels = 6'b01_00_10;
            5'h1E: decode_levels = 6'b01_01_00;
            5'h1F: decode_levels = 6'b01_01_10;
            default: decode_levels = 6'b00_00_00;
        endcase
    endfunction

    function automatic logic [DAC_W-1:0] dac_level(input logic [1:0] level);
        case (level)
            2'd1:    dac_level = DAC_MID;
            2'd2:    dac_level = DAC_FULL;
            default: dac_level = {DAC_W{1'b0}};
        endcase
    endfunction

    logic [4:0]       r_pal [NUM_PENS];
    logic [4:0]       r_border;
    logic [4:0]       r_colour;
    logic             r_blank1;
    logic             r_red, r_green, r_blue;
    logic             r_red_oen, r_green_oen, r_blue_oen;
    logic [DAC_W-1:0] r_dac_r, r_dac_g, r_dac_b;
    logic             r_blank_out;

    logic [4:0] w_lookup;
    logic [5:0] w_levels;
    logic [1:0] w_lv_r, w_lv_g, w_lv_b;

    // Palette storage; writes ignore CE and land after this cycle's stage-1 read.
    always_ff @(posedge CLK_n) begin
        if (RESET) begin
            for (int i = 0; i < NUM_PENS; i++) begin
                r_pal[i] <= BLACK;
            end
            r_border <= BLACK;
        end else if (bus.PAL_WR) begin
            if (bus.PAL_BORDER) begin
                r_border <= bus.PAL_DATA;
            end else begin
                r_pal[bus.PAL_ADDR] <= bus.PAL_DATA;
            end
        end else begin
            r_border <= r_border;
        end
    end

    // Stage-1 palette lookup.
    always_comb begin
        w_lookup = BLACK;
        if (bus.BORDER) begin
            w_lookup = r_border;
        end else begin
            w_lookup = r_pal[bus.PEN];
        end
    end

    // Stage-1 colour and blank registers.
    always_ff @(posedge CLK_n) begin
        if (RESET) begin
            r_colour <= BLACK;
            r_blank1 <= 1'b1;
        end else if (bus.CE) begin
            r_colour <= w_lookup;
            r_blank1 <= bus.BLANK;
        end else begin
            r_colour <= r_colour;
            r_blank1 <= r_blank1;
        end
    end

    // Stage-2 decode with blanking forcing every channel to level 0.
    always_comb begin
        w_levels = 6'b00_00_00;
        if (r_blank1) begin
            w_levels = 6'b00_00_00;
        end else begin
            w_levels = decode_levels(r_colour);
        end
        w_lv_r = w_levels[5:4];
        w_lv_g = w_levels[3:2];
        w_lv_b = w_levels[1:0];
    end

    // Stage-2 output registers; mid level floats the pin with OEn high.
    always_ff @(posedge CLK_n) begin
        if (RESET) begin
            r_red       <= 1'b0;
            r_green     <= 1'b0;
            r_blue      <= 1'b0;
            r_red_oen   <= 1'b0;
            r_green_oen <= 1'b0;
            r_blue_oen  <= 1'b0;
            r_dac_r     <= {DAC_W{1'b0}};
            r_dac_g     <= {DAC_W{1'b0}};
            r_dac_b     <= {DAC_W{1'b0}};
            r_blank_out <= 1'b1;
        end else if (bus.CE) begin
            r_red       <= (w_lv_r == 2'd2);
            r_green     <= (w_lv_g == 2'd2);
            r_blue      <= (w_lv_b == 2'd2);
            r_red_oen   <= (w_lv_r == 2'd1);
            r_green_oen <= (w_lv_g == 2'd1);
            r_blue_oen  <= (w_lv_b == 2'd1);
            r_dac_r     <= dac_level(w_lv_r);
            r_dac_g     <= dac_level(w_lv_g);
            r_dac_b     <= dac_level(w_lv_b);
            r_blank_out <= r_blank1;
        end else begin
            r_blank_out <= r_blank_out;
        end
    end

    assign bus.RED       = r_red;
    assign bus.GREEN     = r_green;
    assign bus.BLUE      = r_blue;
    assign bus.RED_OEn   = r_red_oen;
    assign bus.GREEN_OEn = r_green_oen;
    assign bus.BLUE_OEn  = r_blue_oen;
    assign bus.DAC_R     = r_dac_r;
    assign bus.DAC_G     = r_dac_g;
    assign bus.DAC_B     = r_dac_b;
    assign bus.BLANK_OUT = r_blank_out;
endmodule

// File: tb/tb_palette_colour_out.sv
// Scoreboard bench driving three palette_colour_out configurations in lockstep:
// 16 pens/DAC_W=4, 2 pens/DAC_W=2, 16 pens/DAC_W=6.
module tb_palette_colour_out;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    palette_colour_out_if #(.PEN_W(4), .DAC_W(4)) bus0 ();
    palette_colour_out_if #(.PEN_W(1), .DAC_W(2)) bus1 ();
    palette_colour_out_if #(.PEN_W(4), .DAC_W(6)) bus2 ();

    palette_colour_out #(.NUM_PENS(16), .DAC_W(4)) u_dut0 (.CLK_n(clk), .RESET(rst), .bus(bus0));
    palette_colour_out #(.NUM_PENS(2),  .DAC_W(2)) u_dut1 (.CLK_n(clk), .RESET(rst), .bus(bus1));
    palette_colour_out #(.NUM_PENS(16), .DAC_W(6)) u_dut2 (.CLK_n(clk), .RESET(rst), .bus(bus2));

    // R,G,B levels per hardware colour, written as three decimal digits.
    localparam int LV [32] = '{111, 111,  21, 221,   1, 201,  11, 211,
                               201, 221, 220, 222, 200, 202, 210, 212,
                                 1,  21,  20,  22,   0,   2,  10,  12,
                               101, 121, 120, 122, 100, 102, 110, 112};

    typedef struct packed {
        int          id;
        logic [6:0]  p16;
        logic [6:0]  p2;
        logic [17:0] d4;
        logic [17:0] d2;
        logic [17:0] d6;
    } exp_t;

    exp_t       sb[$];
    exp_t       last_e;
    logic [4:0] m_pal16 [16];
    logic [4:0] m_pal2  [2];
    logic [4:0] m_bord;
    int         n_assert = 0;
    int         n_fail   = 0;
    int         n_pix    = 0;

    // Pins packed {R,G,B drive, R,G,B OEn, BLANK_OUT}.
    function automatic logic [6:0] exp_pins(input logic [4:0] c, input logic blk);
        int v = LV[c];
        int r = v / 100;
        int g = (v / 10) % 10;
        int b = v % 10;
        if (blk) begin r = 0; g = 0; b = 0; end
        return {r == 2, g == 2, b == 2, r == 1, g == 1, b == 1, blk};
    endfunction

    function automatic logic [5:0] lvl_to_dac(input int l, input int dw);
        if (l == 2) return 6'((1 << dw) - 1);
        if (l == 1) return 6'(1 << (dw - 1));
        return 6'd0;
    endfunction

    function automatic logic [17:0] exp_dac(input logic [4:0] c, input logic blk, input int dw);
        int v = blk ? 0 : LV[c];
        return {lvl_to_dac(v / 100, dw), lvl_to_dac((v / 10) % 10, dw), lvl_to_dac(v % 10, dw)};
    endfunction

    task automatic cmp(input string tag, input logic [17:0] obs, input logic [17:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input exp_t e, input string tag);
        cmp($sformatf("%s_pins16", tag), {11'd0, bus0.RED, bus0.GREEN, bus0.BLUE,
            bus0.RED_OEn, bus0.GREEN_OEn, bus0.BLUE_OEn, bus0.BLANK_OUT}, {11'd0, e.p16});
        cmp($sformatf("%s_dac4", tag), {2'd0, bus0.DAC_R, 2'd0, bus0.DAC_G, 2'd0, bus0.DAC_B}, e.d4);
        cmp($sformatf("%s_pins2", tag), {11'd0, bus1.RED, bus1.GREEN, bus1.BLUE,
            bus1.RED_OEn, bus1.GREEN_OEn, bus1.BLUE_OEn, bus1.BLANK_OUT}, {11'd0, e.p2});
        cmp($sformatf("%s_dac2", tag), {4'd0, bus1.DAC_R, 4'd0, bus1.DAC_G, 4'd0, bus1.DAC_B}, e.d2);
        cmp($sformatf("%s_pins16w6", tag), {11'd0, bus2.RED, bus2.GREEN, bus2.BLUE,
            bus2.RED_OEn, bus2.GREEN_OEn, bus2.BLUE_OEn, bus2.BLANK_OUT}, {11'd0, e.p16});
        cmp($sformatf("%s_dac6", tag), {bus2.DAC_R, bus2.DAC_G, bus2.DAC_B}, e.d6);
    endtask

    task automatic set_inputs(input logic ce, input logic [3:0] pen, input logic brd, input logic blk,
                              input logic wr, input logic wb, input logic [3:0] wa, input logic [4:0] wd);
        bus0.CE = ce; bus0.PEN = pen; bus0.BORDER = brd; bus0.BLANK = blk;
        bus0.PAL_WR = wr; bus0.PAL_BORDER = wb; bus0.PAL_ADDR = wa; bus0.PAL_DATA = wd;
        bus1.CE = ce; bus1.PEN = pen[0]; bus1.BORDER = brd; bus1.BLANK = blk;
        bus1.PAL_WR = wr; bus1.PAL_BORDER = wb; bus1.PAL_ADDR = wa[0]; bus1.PAL_DATA = wd;
        bus2.CE = ce; bus2.PEN = pen; bus2.BORDER = brd; bus2.BLANK = blk;
        bus2.PAL_WR = wr; bus2.PAL_BORDER = wb; bus2.PAL_ADDR = wa; bus2.PAL_DATA = wd;
    endtask

    // One CE pixel: expectation pushed now, the pixel from the previous step checked after the edge.
    task automatic pixel(input logic [3:0] pen, input logic brd, input logic blk,
                         input logic wr = 1'b0, input logic wb = 1'b0,
                         input logic [3:0] wa = 4'd0, input logic [4:0] wd = 5'd0);
        exp_t       e;
        logic [4:0] c16;
        logic [4:0] c2;
        set_inputs(1'b1, pen, brd, blk, wr, wb, wa, wd);
        c16  = brd ? m_bord : m_pal16[pen];
        c2   = brd ? m_bord : m_pal2[pen[0]];
        e.id = n_pix;
        e.p16 = exp_pins(c16, blk);
        e.p2  = exp_pins(c2, blk);
        e.d4  = exp_dac(c16, blk, 4);
        e.d2  = exp_dac(c2, blk, 2);
        e.d6  = exp_dac(c16, blk, 6);
        sb.push_back(e);
        n_pix++;
        @(posedge clk);
        if (wr) begin
            if (wb) begin
                m_bord = wd;
            end else begin
                m_pal16[wa] = wd;
                m_pal2[wa[0]] = wd;
            end
        end
        #1;
        if (sb.size() == 2) begin
            last_e = sb.pop_front();
            check_outputs(last_e, $sformatf("px%0d", last_e.id));
        end
    endtask

    task automatic hold(input int n);
        set_inputs(1'b0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_outputs(last_e, $sformatf("hold%0d", i));
        end
    endtask

    // Reset with CE and a palette write both active; the write must be dropped.
    task automatic do_reset();
        exp_t e;
        rst = 1'b1;
        set_inputs(1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 5'h0B);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 16; i++) m_pal16[i] = 5'h14;
        m_pal2[0] = 5'h14;
        m_pal2[1] = 5'h14;
        m_bord = 5'h14;
        e = '0;
        e.p16 = 7'b000_000_1;
        e.p2  = 7'b000_000_1;
        last_e = e;
        check_outputs(e, "reset");
    endtask

    initial begin
        set_inputs(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        // Pen 3 still black after the ignored write.
        pixel(4'd3, 1'b0, 1'b0);
        // Pen 5 = 0x0B: full white.
        pixel(4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 5'h0B);
        pixel(4'd5, 1'b0, 1'b0);
        // Pen 2 = 0x00: all mid, then 0x0E: full/mid/off.
        pixel(4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 5'h00);
        pixel(4'd2, 1'b0, 1'b0);
        pixel(4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 5'h0E);
        pixel(4'd2, 1'b0, 1'b0);
        // Border blue with BLANK toggling.
        pixel(4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 5'h15);
        pixel(4'd0, 1'b1, 1'b0);
        pixel(4'd0, 1'b1, 1'b1);
        pixel(4'd0, 1'b1, 1'b0);
        // Write/read collision on pen 1 reads the old black, then bright green.
        pixel(4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 5'h12);
        pixel(4'd1, 1'b0, 1'b0);
        pixel(4'd5, 1'b0, 1'b0);
        hold(3);
        pixel(4'd2, 1'b0, 1'b0);
        // Random pixels with interleaved palette writes.
        for (int i = 0; i < 40; i++) begin
            pixel(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                  4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
        end
        // Reset mid-frame discards the in-flight pixels.
        do_reset();
        pixel(4'd5, 1'b0, 1'b0);
        pixel(4'd1, 1'b1, 1'b0);
        pixel(4'd0, 1'b0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
